mux4to1_rr_arbiter: RTL and testbench
=====================================

Name: mux4to1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 multiplexed data channel among four requesters.
- Generates the 2-bit select for the channel mux, a one-hot grant back to the requesters, and a valid-qualified output word.
- Sits in front of the mux4to1 datapath. Also instantiates the 4:1 selection of W-bit data internally, so the channel output is self-contained.

Parameters:
- W, 1, data width per requester and of the output word.
- MAX_HOLD, 4, max consecutive cycles one requester keeps the grant while another requester waits (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; req[0]=a, req[1]=b, req[2]=c, req[3]=d.
- data_in  input  4*W  packed data; requester i occupies bits [i*W +: W].
- gnt  output  4  registered one-hot grant; all-zero when idle.
- sel  output  2  registered mux select; equals index of the granted requester.
- out_valid  output  1  high while a grant is held; equals |gnt.
- out_data  output  W  data_in slice selected by sel; combinational from the sel register and data_in.

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on the rising edge of clk).
  - Reset values: gnt=4'b0000, sel=2'b00, out_valid=0, out_data=data_in[0 +: W], priority pointer ptr=0, hold counter cnt=0, state=IDLE.
  - rst mid-grant drops the grant on the next edge with no completion of the burst. rst wins over all other events.
- State IDLE (gnt=0):
  - If req!=0 at an edge: choose the first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
  - Register gnt=1<<i, sel=i, cnt=0; go to GRANT.
  - Grant is visible one cycle after the request is sampled (latency 1).
- State GRANT (granted index g=sel), evaluated each edge:
  - release = !req[g] OR (cnt==MAX_HOLD-1 AND (req & ~(1<<g))!=0).
  - No release: keep gnt/sel; cnt saturates at MAX_HOLD-1.
  - Release: ptr <= g+1 mod 4 (2-bit wrap, 3→0).
    - If any request remains after masking req[g] when the release was forced by hold expiry, pick the next winner from g+1 onward in the same edge: new gnt/sel, cnt=0, stay in GRANT. There is no idle bubble between grants.
    - If no other requester is waiting and req[g] has dropped, go to IDLE: gnt=0, sel holds its last value.
- A sole requester with continuous req keeps the grant indefinitely. Hold expiry only applies when another requester is waiting.
- A requester dropping req while granted loses the grant at that edge. Requests arriving in the same cycle as a release participate in selection for that edge.
- Invariants: gnt is always one-hot or zero; out_valid==|gnt; when gnt!=0, gnt==1<<sel.
- out_data tracks data_in changes combinationally for the granted slice. Its value is don't-care when out_valid=0, but it must still equal the sel slice.
- Widths: cnt is 8 bits; ptr and sel are 2 bits with natural modulo-4 wrap.

Test Plan:
- Reset: hold rst=1 with req=4'b1111 for 2 cycles → gnt=0, sel=0, out_valid=0. Release rst → next edge gnt=4'b0001, sel=0.
- Single request: req=4'b0100, data_in[2*W +: W]=1 (W=1) → after 1 edge gnt=4'b0100, sel=2, out_data=1. Drop req → next edge gnt=0, out_valid=0; ptr=3 (a later req=4'b1001 is granted to d first).
- Round-robin fairness: req=4'b1111 held, MAX_HOLD=4 → grants rotate 0,1,2,3,0, each held exactly 4 cycles, no gap cycles. out_data follows a,b,c,d.
- Sole holder: req=4'b0010 held for 20 cycles → gnt=4'b0010 for all 20 cycles. Raise req[3] at cycle 10 → d is granted within MAX_HOLD edges of that cycle.
- Wrap and early drop: grant on d (sel=3), d drops req while req=4'b0011 → next edge gnt=4'b0001 (ptr wrapped to 0), no idle cycle.
- Mid-burst reset: grant on c, assert rst for 1 cycle → gnt=0, ptr=0. With req=4'b1100 afterwards → c is granted first.

Source files
------------

// File: rtl/mux4to1_rr_arbiter.sv
// mux4to1_rr_arbiter: round-robin arbiter with hold limit driving a 4:1 W-bit data mux
module mux4to1_rr_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data_in,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data
);
  localparam logic       IDLE      = 1'b0;
  localparam logic       GRANT     = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic       state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d, ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] others, cand;
  logic [1:0] start, win, idx;
  logic       release_w;
  always_comb begin
    others    = req & ~(4'b0001 << sel_q);
    release_w = !req[sel_q] || (cnt_q == HOLD_LAST && others != 4'b0000);
    // In GRANT the search starts just past the current holder, which also becomes the new ptr
    start     = state_q == GRANT ? sel_q + 2'd1 : ptr_q;
    cand      = state_q == GRANT ? others : req;
    win       = start;
    idx       = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (cand[idx]) win = idx;
    end
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (req != 4'b0000) begin
        state_d = GRANT;
        gnt_d   = 4'b0001 << win;
        sel_d   = win;
        cnt_d   = 8'd0;
      end
    end else if (!release_w) begin
      cnt_d = cnt_q == HOLD_LAST ? cnt_q : cnt_q + 8'd1;
    end else begin
      ptr_d   = sel_q + 2'd1;
      cnt_d   = 8'd0;
      state_d = others != 4'b0000 ? GRANT : IDLE;
      gnt_d   = others != 4'b0000 ? 4'b0001 << win : 4'b0000;
      sel_d   = others != 4'b0000 ? win : sel_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = |gnt_q;
  assign out_data  = data_in[sel_q*W +: W];
endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// tb_mux4to1_rr_arbiter: directed stimulus checked against an owner/held-cycles model of the arbiter
module tb_mux4to1_rr_arbiter;
  localparam int W = 1;
  localparam int MAX_HOLD = 4;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [4*W-1:0] data_in;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  int checks = 0;
  int errors = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_held = 0;
  int m_sel = 0;
  mux4to1_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic int first_from(input logic [3:0] m, input int s);
    for (int k = 0; k < 4; k++)
      if (m[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction
  always @(posedge clk) begin
    logic [3:0] oth;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (req != 4'b0000) begin
        m_owner = first_from(req, m_ptr); m_held = 1; m_sel = m_owner;
      end
    end else begin
      oth = req & ~(4'b0001 << m_owner);
      if (!req[m_owner] || (m_held >= MAX_HOLD && oth != 4'b0000)) begin
        m_ptr = (m_owner + 1) % 4;
        m_owner = oth != 4'b0000 ? first_from(oth, m_ptr) : -1;
        m_held = 1;
        if (m_owner >= 0) m_sel = m_owner;
      end else m_held++;
    end
    #1;
    chk("model_gnt", gnt, m_owner < 0 ? 0 : (1 << m_owner));
    chk("model_valid", out_valid, m_owner >= 0);
    chk("model_sel", sel, m_sel);
    chk("model_data", out_data, data_in[m_sel*W +: W]);
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; req = 4'b1111; data_in = '0;
    step(2);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_sel", sel, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    rst = 1'b0;
    step(1);
    chk("post_rst_gnt", gnt, 4'b0001);
    chk("post_rst_sel", sel, 2'd0);
    req = 4'b0000;
    step(1);
    chk("drop_a_gnt", gnt, 4'b0000);
    data_in = 4'b0100; req = 4'b0100;
    step(1);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", sel, 2'd2);
    chk("single_data", out_data, 1'b1);
    req = 4'b0000;
    step(1);
    chk("single_drop_gnt", gnt, 4'b0000);
    chk("single_drop_valid", out_valid, 1'b0);
    req = 4'b1001;
    step(1);
    chk("ptr3_gnt", gnt, 4'b1000);
    req = 4'b0000;
    step(1);
    data_in = 4'b0101; req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("rr_gnt", gnt, 4'b0001 << ((k / 4) % 4));
      chk("rr_data", out_data, ((k / 4) % 2) == 0);
    end
    req = 4'b0000;
    step(1);
    req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("sole_gnt", gnt, 4'b0010);
    end
    req = 4'b1010;
    step(1);
    chk("sole_expire_gnt", gnt, 4'b1000);
    chk("sole_expire_sel", sel, 2'd3);
    req = 4'b0011;
    step(1);
    chk("wrap_gnt", gnt, 4'b0001);
    req = 4'b0100;
    step(1);
    chk("c_gnt", gnt, 4'b0100);
    data_in = 4'b0000;
    #1 chk("comb_data0", out_data, 1'b0);
    data_in = 4'b0100;
    #1 chk("comb_data1", out_data, 1'b1);
    rst = 1'b1;
    step(1);
    chk("midrst_gnt", gnt, 4'b0000);
    rst = 1'b0; req = 4'b1100;
    step(1);
    chk("midrst_c_first", gnt, 4'b0100);
    req = 4'b0000;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
